bus_transfer_sequencer: RTL and testbench
=========================================

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 Parameter DIV, default 4: slow_clk tick period in clk cycles, minimum 2.
REQ-002 Parameter WIDTH, default 4: data_bus width.
REQ-003 Port clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port req  input  1: transfer request; sampled only in IDLE on a slow_clk tick.
REQ-006 Port src_sel  input  2: source register index whose oe is driven.
REQ-007 Port dst_sel  input  2: destination register index whose load is driven.
REQ-008 Port step_mode  input  1: 1 = advance FSM only on clk_step rising edges; 0 = free-run on slow_clk ticks.
REQ-009 Port clk_step  input  1: asynchronous manual step button.
REQ-010 Port data_bus  input  WIDTH: shared bus value, observed during transfers.
REQ-011 Port oe  output  4: one-hot output-enable to source registers.
REQ-012 Port load  output  4: one-hot load strobe to destination registers.
REQ-013 Port slow_clk  output  1: one-clk-cycle tick every DIV clk cycles.
REQ-014 Port busy  output  1: high in any state other than IDLE.
REQ-015 Port done  output  1: one-clk-cycle pulse on completion.
REQ-016 Port err  output  1: one-clk-cycle pulse when a request is rejected.
REQ-017 Port register_state  output  WIDTH: last value captured from data_bus.

Function
REQ-018 Divider counts 0..DIV-1 and wraps; slow_clk is high on the cycle the count equals DIV-1.
REQ-019 clk_step passes a 2-flop synchronizer; a step event is a 0->1 transition of the synchronized signal, one clk cycle wide.
REQ-020 Advance enable = step event when step_mode=1, else slow_clk; the FSM changes state only on advance enable.
REQ-021 States: IDLE, DRIVE, LATCH, RELEASE.
REQ-022 IDLE to DRIVE on advance when req=1 and src_sel != dst_sel; src_sel/dst_sel are latched internally at that point.
REQ-023 On advance in IDLE with req=1 and src_sel == dst_sel: stay IDLE and pulse err for one clk cycle.
REQ-024 DRIVE: oe[src] = 1, load = 0; on advance go to LATCH.
REQ-025 LATCH: oe[src] = 1 and load[dst] = 1 for exactly one clk cycle, entered on advance.
REQ-026 In the LATCH cycle, data_bus is captured into register_state.
REQ-027 LATCH moves to RELEASE on the next clk cycle, independent of advance enable.
REQ-028 RELEASE: oe[src] = 1, load = 0; on advance go to IDLE and pulse done for one clk cycle.
REQ-029 oe and load are all-zero in IDLE; at most one bit of each is set at any time.
REQ-030 Changes to src_sel/dst_sel after latching do not affect the transfer in progress.
REQ-031 req=1 held in IDLE after done starts a new transfer on the next advance.
REQ-032 Toggling step_mode mid-transfer takes effect on the next clk cycle; the FSM state is preserved.
REQ-033 All outputs are registered.

Reset
REQ-034 While rst=1 on a clk edge: FSM = IDLE, divider = 0, synchronizer flops = 0, latched selects = 0.
REQ-035 While rst=1 on a clk edge: oe = 0, load = 0, slow_clk = 0, busy = 0, done = 0, err = 0, register_state = 0.
REQ-036 rst asserted mid-transfer aborts it with no done pulse; load is never asserted on the rst cycle.

Verification
REQ-037 Free-run, DIV=4: rst 2 cycles; req=1, src=0, dst=2, data_bus=4'b1010 -> oe=0001 for 4 cycles; then load=0100 for one cycle; register_state=1010; done pulses; busy falls.
REQ-038 src=1, dst=1, req=1 -> err pulses once per slow_clk tick while req is held; oe and load stay 0; busy stays 0.
REQ-039 step_mode=1, three clk_step presses each held for 10 cycles -> one state advance per press: DRIVE, LATCH->RELEASE, IDLE; no advance while the button is held.
REQ-040 rst=1 during DRIVE -> next cycle oe=0, busy=0, no done; a fresh req completes normally.
REQ-041 src/dst change during DRIVE -> load still asserts on the originally latched dst only.
REQ-042 Divider check: slow_clk high exactly every 4th clk cycle; first tick on cycle 4 after rst release.

Source files
------------

// File: rtl/bus_transfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_transfer_sequencer
//  Description : Sequences one register-to-register transfer over a shared
//                bus. A request in IDLE latches the source and destination
//                selects. The FSM then walks DRIVE -> LATCH -> RELEASE ->
//                IDLE. Progress is paced either by an internal slow_clk tick
//                or by a synchronized manual step button. LATCH always lasts
//                one clk cycle, and in that cycle the bus is captured into
//                register_state.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_sequencer #(
    parameter int DIV   = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       src_sel,
    input  logic [1:0]       dst_sel,
    input  logic             step_mode,
    input  logic             clk_step,
    input  logic [WIDTH-1:0] data_bus,
    output logic [3:0]       oe,
    output logic [3:0]       load,
    output logic             slow_clk,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] register_state
);

    // Divider counter width; DIV is at least 2, so this is at least one bit.
    localparam int                 c_cnt_w    = $clog2(DIV);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_LATCH   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_div_cnt;
    logic               r_slow_clk;

    logic               r_step_meta;
    logic               r_step_sync;
    logic               r_step_prev;

    state_t             r_state;
    logic [1:0]         r_src;
    logic [1:0]         r_dst;
    logic [3:0]         r_oe;
    logic [3:0]         r_load;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [WIDTH-1:0]   r_register_state;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] w_div_next;
    logic               w_step_evt;
    logic               w_advance;

    // Binary select index to one-hot strobe.
    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_div_next = (r_div_cnt == c_div_last) ? '0 : (r_div_cnt + c_cnt_one);

    // The step event is the rising edge of the synchronized button.
    // It lasts exactly one clk cycle, so a button held down fires only once.
    assign w_step_evt = r_step_sync & ~r_step_prev;

    // step_mode is used directly here, so a mode change applies on the very
    // next clk edge. The FSM state itself is not disturbed.
    assign w_advance  = step_mode ? w_step_evt : r_slow_clk;

    // Free-running divider; the tick is registered and lines up with count == DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_slow_clk <= 1'b0;
        end else begin
            r_div_cnt  <= w_div_next;
            r_slow_clk <= (w_div_next == c_div_last);
        end
    end

    // Two-flop synchronizer for the manual step button, plus a delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_meta <= clk_step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
        end
    end

    // Transfer FSM; every output is computed alongside the state so all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_src            <= 2'd0;
            r_dst            <= 2'd0;
            r_oe             <= 4'b0000;
            r_load           <= 4'b0000;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            r_register_state <= '0;
        end else begin
            // done and err are single-cycle pulses unless re-armed below.
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_oe   <= 4'b0000;
                    r_load <= 4'b0000;
                    if (w_advance && req) begin
                        if (src_sel != dst_sel) begin
                            // Freeze the selects so later changes cannot
                            // redirect a transfer that is already running.
                            r_src   <= src_sel;
                            r_dst   <= dst_sel;
                            r_oe    <= f_onehot(src_sel);
                            r_busy  <= 1'b1;
                            r_state <= S_DRIVE;
                        end else begin
                            // Copying a register onto itself is rejected.
                            r_err <= 1'b1;
                        end
                    end
                end

                S_DRIVE: begin
                    if (w_advance) begin
                        r_load  <= f_onehot(r_dst);
                        r_state <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    // A single-cycle state: capture the bus and drop the load
                    // strobe without waiting for another advance.
                    r_register_state <= data_bus;
                    r_load           <= 4'b0000;
                    r_state          <= S_RELEASE;
                end

                S_RELEASE: begin
                    if (w_advance) begin
                        r_oe    <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_oe    <= 4'b0000;
                    r_load  <= 4'b0000;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oe             = r_oe;
    assign load           = r_load;
    assign slow_clk       = r_slow_clk;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign register_state = r_register_state;

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_transfer_sequencer
//  Description : Self-checking bench for bus_transfer_sequencer. Each request
//                pushes its expected oe/load/data to a queue. A negedge
//                monitor pops one entry on every done pulse and compares it
//                against what the DUT actually strobed and captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_sequencer;

    localparam int c_div   = 4;
    localparam int c_width = 4;

    logic               clk       = 1'b0;
    logic               rst       = 1'b1;
    logic               req       = 1'b0;
    logic [1:0]         src_sel   = 2'd0;
    logic [1:0]         dst_sel   = 2'd0;
    logic               step_mode = 1'b0;
    logic               clk_step  = 1'b0;
    logic [c_width-1:0] data_bus  = '0;
    logic [3:0]         oe;
    logic [3:0]         load;
    logic               slow_clk;
    logic               busy;
    logic               done;
    logic               err;
    logic [c_width-1:0] register_state;

    bus_transfer_sequencer #(
        .DIV   (c_div),
        .WIDTH (c_width)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .src_sel        (src_sel),
        .dst_sel        (dst_sel),
        .step_mode      (step_mode),
        .clk_step       (clk_step),
        .data_bus       (data_bus),
        .oe             (oe),
        .load           (load),
        .slow_clk       (slow_clk),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .register_state (register_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]         oe;
        logic [3:0]         load;
        logic [c_width-1:0] data;
    } xfer_t;

    xfer_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic       mon_en    = 1'b0;
    logic [3:0] seen_oe   = 4'b0;
    logic [3:0] seen_load = 4'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic press_step();
        clk_step = 1'b1;
        repeat (10) @(negedge clk);
        clk_step = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Monitor: per-cycle invariants plus scoreboard compare on every done pulse.
    always @(negedge clk) begin : mon
        xfer_t e;
        if (mon_en) begin
            chk("oe_onehot", ($countones(oe) <= 1), 1);
            chk("load_onehot", ($countones(load) <= 1), 1);
            chk("idle_quiet", (busy || (oe == 4'b0 && load == 4'b0)), 1);
            if (load != 4'b0) begin
                load_cnt++;
                seen_oe   = oe;
                seen_load = load;
            end
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                chk("sb_depth_at_done", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("xfer_oe", seen_oe, e.oe);
                    chk("xfer_load", seen_load, e.load);
                    chk("xfer_data", register_state, e.data);
                end
            end
        end
    end

    initial begin
        int n;
        int c0;
        logic ok;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_oe", oe, 0);
        chk("rst_load", load, 0);
        chk("rst_slow_clk", slow_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_register_state", register_state, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Divider phase: count 0 in the release cycle, tick on the 4th cycle
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("slow_clk_phase", slow_clk, (i % 4 == 3));
        end

        // Free-running transfer 0 -> 2
        src_sel  = 2'd0;
        dst_sel  = 2'd2;
        data_bus = 4'b1010;
        req      = 1'b1;
        exp_q.push_back(xfer_t'{4'b0001, 4'b0100, 4'b1010});
        wait_busy("t1_start");
        req = 1'b0;
        chk("t1_oe_drive", oe, 4'b0001);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load != 4'b0) break;
            n++;
        end
        chk("t1_drive_len", n, 4);
        chk("t1_load", load, 4'b0100);
        chk("t1_oe_latch", oe, 4'b0001);
        @(negedge clk);
        chk("t1_load_width", load, 0);
        chk("t1_capture", register_state, 4'b1010);
        wait_done("t1_done");
        chk("t1_busy_fall", busy, 0);
        chk("t1_oe_release", oe, 0);

        // Rejected request: src == dst
        @(negedge clk);
        src_sel = 2'd1;
        dst_sel = 2'd1;
        req     = 1'b1;
        c0      = err_cnt;
        ok      = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy || oe != 4'b0 || load != 4'b0) ok = 1'b0;
        end
        req = 1'b0;
        @(negedge clk);
        chk("err_count", err_cnt - c0, 3);
        chk("err_quiet", ok, 1);

        // Manual step mode: one advance per press, regardless of how long it is held
        repeat (3) @(negedge clk);
        step_mode = 1'b1;
        src_sel   = 2'd3;
        dst_sel   = 2'd1;
        data_bus  = 4'b0110;
        req       = 1'b1;
        exp_q.push_back(xfer_t'{4'b1000, 4'b0010, 4'b0110});
        repeat (8) @(negedge clk);
        chk("step_no_tick_advance", busy, 0);
        press_step();
        req = 1'b0;
        chk("step1_busy", busy, 1);
        chk("step1_oe", oe, 4'b1000);
        chk("step1_load", load, 0);
        c0 = load_cnt;
        press_step();
        chk("step2_load_pulses", load_cnt - c0, 1);
        chk("step2_busy", busy, 1);
        chk("step2_oe", oe, 4'b1000);
        chk("step2_capture", register_state, 4'b0110);
        c0 = done_cnt;
        press_step();
        chk("step3_done_pulses", done_cnt - c0, 1);
        chk("step3_busy", busy, 0);
        chk("step3_oe", oe, 0);

        // Abort during DRIVE, then a fresh transfer
        step_mode = 1'b0;
        src_sel   = 2'd2;
        dst_sel   = 2'd0;
        data_bus  = 4'b0011;
        req       = 1'b1;
        wait_busy("abort_start");
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_oe", oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_load", load, 0);
        c0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - c0, 0);
        req = 1'b1;
        exp_q.push_back(xfer_t'{4'b0100, 4'b0001, 4'b0011});
        wait_busy("fresh_start");
        req = 1'b0;
        wait_done("fresh_done");

        // Select changes after latching must not redirect the transfer
        src_sel  = 2'd1;
        dst_sel  = 2'd3;
        data_bus = 4'b1100;
        req      = 1'b1;
        exp_q.push_back(xfer_t'{4'b0010, 4'b1000, 4'b1100});
        wait_busy("sel_start");
        src_sel = 2'd0;
        dst_sel = 2'd2;
        req     = 1'b0;
        wait_done("sel_done");

        // Request held through done starts the next transfer straight away
        src_sel  = 2'd0;
        dst_sel  = 2'd1;
        data_bus = 4'b0101;
        req      = 1'b1;
        exp_q.push_back(xfer_t'{4'b0001, 4'b0010, 4'b0101});
        exp_q.push_back(xfer_t'{4'b0001, 4'b0010, 4'b0101});
        wait_busy("b2b_first_start");
        wait_done("b2b_first_done");
        n = 0;
        while (!busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_restart", busy, 1);
        req = 1'b0;
        wait_done("b2b_second_done");

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
